dmem_lsu: RTL and testbench

- Memory-side responder for the pipeline controller's store/load controls (DCache_WE, ST_Size, LD_Size).
- Accepts one X-stage memory request per cycle.
- Drives the data cache with a word address, replicated store data and a 4-bit byte-write mask.
- Tracks the outstanding load, then sign/zero-extends and aligns the returned word in the M stage.
- Asserts a stall back to the pipeline whenever the cache cannot accept a request or a load response is overdue.

---
 rtl/dmem_lsu_pkg.sv | 41 ++++
 rtl/dmem_lsu_load_extend.sv | 28 ++
 rtl/dmem_lsu.sv | 127 ++++++++++++
 tb/tb_dmem_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
// Holds the size codes, FSM states, byte-mask constants and offset helpers.
package dmem_lsu_pkg;

   localparam logic [1:0] LSU_BYTE = 2'd0;
   localparam logic [1:0] LSU_HALF = 2'd1;
   localparam logic [1:0] LSU_WORD = 2'd2;

   localparam logic [3:0] LSU_MASK_BYTE = 4'b0001;
   localparam logic [3:0] LSU_MASK_HALF = 4'b0011;
   localparam logic [3:0] LSU_MASK_WORD = 4'b1111;

   typedef enum logic {
      LSU_IDLE      = 1'b0,
      LSU_WAIT_RESP = 1'b1
   } lsu_state_e;

   // Half ignores addr[0]; word (and the size=3 alias) ignores addr[1:0].
   function automatic logic [1:0] align_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
      logic [1:0] off;
      case (size)
         LSU_BYTE: off = addr_lo;
         LSU_HALF: off = {addr_lo[1], 1'b0};
         default:  off = 2'd0;
      endcase
      return off;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic mis;
      case (size)
         LSU_BYTE: mis = 1'b0;
         LSU_HALF: mis = addr_lo[0];
         default:  mis = (addr_lo != 2'd0);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Combinational align and sign/zero extension of a returned cache word.
// Kept standalone so an uncached I/O path can reuse it.
module lsu_load_extend
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data_out
);

   logic [31:0] shifted;

   assign shifted = word_in >> {offset, 3'b000};

   always_comb begin
      data_out = shifted;
      case (size)
         LSU_BYTE: data_out = is_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
         LSU_HALF: data_out = is_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
         default:  data_out = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: drives the data cache from X-stage requests and
// returns extended load data. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              ld_valid,
   output logic [31:0]       ld_data,
   output logic              misalign,
   output logic [AWIDTH-3:0] dcache_addr,
   output logic [31:0]       dcache_din,
   output logic [3:0]        dcache_we,
   output logic              dcache_re,
   input  logic              dcache_ready,
   input  logic [31:0]       dcache_dout,
   input  logic              dcache_resp_valid
);

   if (DWIDTH != 32) begin : g_dwidth_check
      $error("dmem_lsu: DWIDTH must be 32");
   end

   lsu_state_e  state_q, state_d;
   logic [1:0]  pend_off_q, pend_off_d;
   logic [1:0]  pend_size_q, pend_size_d;
   logic        pend_uns_q, pend_uns_d;
   logic        misalign_q, misalign_d;

   logic [1:0]  req_off;
   logic        misal_req;
   logic        wait_block;
   logic        blocked;
   logic        issue;
   logic        load_issue;
   logic [3:0]  store_mask;
   logic [31:0] ext_data;

   assign req_off = align_offset(req_size, req_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
   assign misal_req = req_valid & is_misaligned(req_size, req_addr[1:0]);
`else
   assign misal_req = 1'b0;
`endif

   assign wait_block = (state_q == LSU_WAIT_RESP) & ~dcache_resp_valid;
   assign blocked    = wait_block | misal_req;
   assign issue      = req_valid & dcache_ready & ~blocked;
   assign load_issue = issue & ~req_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LSU_IDLE;
         pend_off_q  <= 2'd0;
         pend_size_q <= 2'd0;
         pend_uns_q  <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_off_q  <= pend_off_d;
         pend_size_q <= pend_size_d;
         pend_uns_q  <= pend_uns_d;
         misalign_q  <= misalign_d;
      end
   end

   // A response cycle frees the slot, so a new load may issue alongside it.
   always_comb begin
      state_d     = state_q;
      pend_off_d  = pend_off_q;
      pend_size_d = pend_size_q;
      pend_uns_d  = pend_uns_q;
      misalign_d  = misal_req;
      if (state_q == LSU_IDLE || dcache_resp_valid) begin
         state_d = load_issue ? LSU_WAIT_RESP : LSU_IDLE;
      end
      if (load_issue) begin
         pend_off_d  = req_off;
         pend_size_d = req_size;
         pend_uns_d  = req_unsigned;
      end
   end

   always_comb begin
      case (req_size)
         LSU_BYTE: begin
            store_mask = LSU_MASK_BYTE << req_off;
            dcache_din = {4{req_wdata[7:0]}};
         end
         LSU_HALF: begin
            store_mask = LSU_MASK_HALF << req_off;
            dcache_din = {2{req_wdata[15:0]}};
         end
         default: begin
            store_mask = LSU_MASK_WORD;
            dcache_din = req_wdata;
         end
      endcase
      dcache_addr = req_addr[AWIDTH-1:2];
      dcache_re   = req_valid & ~req_we & ~blocked;
      dcache_we   = (req_valid & req_we & ~blocked) ? store_mask : 4'b0000;
      stall       = (req_valid & ~misal_req & ~dcache_ready) | wait_block;
      ld_valid    = (state_q == LSU_WAIT_RESP) & dcache_resp_valid;
      ld_data     = ld_valid ? ext_data : 32'd0;
      misalign    = misalign_q;
   end

   lsu_load_extend u_load_extend (
      .word_in     (dcache_dout),
      .offset      (pend_off_q),
      .size        (pend_size_q),
      .is_unsigned (pend_uns_q),
      .data_out    (ext_data)
   );

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboarded bench for dmem_lsu: stimulus pushes expected load data, a monitor
// pops on every ld_valid. Expectations follow MISALIGN_TRAP_EN when defined.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, ld_valid, misalign;
   logic [31:0] ld_data;
   logic [29:0] dcache_addr;
   logic [31:0] dcache_din;
   logic [3:0]  dcache_we;
   logic        dcache_re;
   logic        dcache_ready;
   logic [31:0] dcache_dout;
   logic        dcache_resp_valid;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   dmem_lsu #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_we            (req_we),
      .req_size          (req_size),
      .req_unsigned      (req_unsigned),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .stall             (stall),
      .ld_valid          (ld_valid),
      .ld_data           (ld_data),
      .misalign          (misalign),
      .dcache_addr       (dcache_addr),
      .dcache_din        (dcache_din),
      .dcache_we         (dcache_we),
      .dcache_re         (dcache_re),
      .dcache_ready      (dcache_ready),
      .dcache_dout       (dcache_dout),
      .dcache_resp_valid (dcache_resp_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every ld_valid consumes one scoreboard entry.
   always @(negedge clk) begin
      if (!reset && ld_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ld_valid: got data %h expected no response", ld_data);
         end else begin
            logic [31:0] exp;
            exp = sb_q.pop_front();
            $display("load response data=%h expected=%h", ld_data, exp);
            chk("ld_data", ld_data, exp);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
      req_valid    = v;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
   endtask

   task automatic resp(input logic rv, input logic [31:0] d);
      dcache_resp_valid = rv;
      dcache_dout       = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      dcache_ready = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      resp(1'b0, 32'h0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_we", {28'd0, dcache_we}, 32'd0);
      chk("rst_re", {31'd0, dcache_re}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);

      // Byte store at offset 3.
      next_cycle();
      reset = 1'b0;
      drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB);
      @(negedge clk);
      $display("store byte addr=1003");
      chk("st_byte_we", {28'd0, dcache_we}, 32'h8);
      chk("st_byte_din", dcache_din, 32'hABAB_ABAB);
      chk("st_byte_addr", {2'b00, dcache_addr}, 32'h400);
      chk("st_byte_stall", {31'd0, stall}, 32'd0);

      // Signed then unsigned byte load at offset 1.
      for (int u = 0; u < 2; u++) begin
         next_cycle();
         drive(1'b1, 1'b0, 2'd0, u[0], 32'h2001, 32'h0);
         sb_q.push_back(u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
         @(negedge clk);
         chk("ld_byte_re", {31'd0, dcache_re}, 32'd1);
         next_cycle();
         drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
         resp(1'b1, 32'h0000_8000);
         @(negedge clk);
         chk("ld_byte_valid", {31'd0, ld_valid}, 32'd1);
         next_cycle();
         resp(1'b0, 32'h0);
      end

      // Three back-to-back word loads with a 1-cycle cache.
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (i < 3) begin
            drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
            sb_q.push_back(32'h1111_1111 * 32'(i + 1));
         end else begin
            drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
         end
         if (i > 0) resp(1'b1, 32'h1111_1111 * 32'(i));
         else       resp(1'b0, 32'h0);
         @(negedge clk);
         chk("b2b_stall", {31'd0, stall}, 32'd0);
         if (i > 0) chk("b2b_ld_valid", {31'd0, ld_valid}, 32'd1);
      end
      next_cycle();
      resp(1'b0, 32'h0);

      // Slow cache: store held for three cycles.
      dcache_ready = 1'b0;
      drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h200, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("slow_st_stall", {31'd0, stall}, 32'd1);
         chk("slow_st_we", {28'd0, dcache_we}, 32'hF);
         next_cycle();
      end
      dcache_ready = 1'b1;
      @(negedge clk);
      chk("slow_st_release", {31'd0, stall}, 32'd0);

      // Load answered 4 cycles later; a half store waits behind it.
      next_cycle();
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
      sb_q.push_back(32'hCAFE_BABE);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h302, 32'h0000_BEEF);
         @(negedge clk);
         chk("wait_stall", {31'd0, stall}, 32'd1);
         chk("wait_st_we", {28'd0, dcache_we}, 32'd0);
      end
      next_cycle();
      resp(1'b1, 32'hCAFE_BABE);
      @(negedge clk);
      chk("resp_stall", {31'd0, stall}, 32'd0);
      chk("held_st_we", {28'd0, dcache_we}, 32'hC);
      chk("held_st_din", dcache_din, 32'hBEEF_BEEF);
      next_cycle();
      resp(1'b0, 32'h0);

      // Reset while a load is outstanding; the late response is dropped.
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
      next_cycle();
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      resp(1'b1, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("late_resp_valid", {31'd0, ld_valid}, 32'd0);
      chk("late_resp_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      resp(1'b0, 32'h0);
      drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h402, 32'h0);
      sb_q.push_back(32'h0000_8001);
      next_cycle();
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      resp(1'b1, 32'h8001_0000);
      next_cycle();
      resp(1'b0, 32'h0);

      // Misaligned half load.
      drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h3001, 32'h0);
`ifndef MISALIGN_TRAP_EN
      sb_q.push_back(32'hFFFF_FFFE);
`endif
      @(negedge clk);
      chk("mis_addr", {2'b00, dcache_addr}, 32'hC00);
`ifdef MISALIGN_TRAP_EN
      chk("mis_re", {31'd0, dcache_re}, 32'd0);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mis_pulse", {31'd0, misalign}, 32'd1);
      chk("mis_idle_stall", {31'd0, stall}, 32'd0);
`else
      chk("mis_re", {31'd0, dcache_re}, 32'd1);
      next_cycle();
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      resp(1'b1, 32'h0000_FFFE);
      @(negedge clk);
      chk("mis_pulse", {31'd0, misalign}, 32'd0);
      chk("mis_ld_valid", {31'd0, ld_valid}, 32'd1);
`endif
      next_cycle();
      resp(1'b0, 32'h0);

      // size=3 behaves as word.
      drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h500, 32'h0);
      sb_q.push_back(32'h89AB_CDEF);
      next_cycle();
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      resp(1'b1, 32'h89AB_CDEF);
      next_cycle();

      // Response while idle is ignored.
      resp(1'b1, 32'h5555_5555);
      @(negedge clk);
      chk("idle_resp_valid", {31'd0, ld_valid}, 32'd0);
      next_cycle();
      resp(1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
